// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin arbiter sharing one register-file write port, with a busy scoreboard.
// Optional R0_ZERO_EN: writes and reservations to register 0 are accepted but never take effect.
module wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_index,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_index,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_index,
    output logic        write_enable,
    output logic [4:0]  write_index,
    output logic [15:0] write_data,
    output logic [31:0] busy
);

    // r_last_grant: 0 = ALU won the most recent handshake, 1 = MEM
    logic        r_last_grant;
    logic        r_write_enable;
    logic [4:0]  r_write_index;
    logic [15:0] r_write_data;
    logic [31:0] r_busy;

    logic        w_grant_alu;
    logic        w_grant_mem;
    logic        w_handshake;
    logic        w_commit;
    logic        w_issue;
    logic [4:0]  w_sel_index;
    logic [15:0] w_sel_data;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                w_grant_alu = r_last_grant;
                w_grant_mem = !r_last_grant;
            end else begin
                w_grant_alu = alu_valid;
                w_grant_mem = mem_valid;
            end
        end
        w_handshake = w_grant_alu | w_grant_mem;
        w_sel_index = w_grant_mem ? mem_index : alu_index;
        w_sel_data  = w_grant_mem ? mem_data  : alu_data;
`ifdef R0_ZERO_EN
        w_commit = w_handshake && (w_sel_index != 5'd0);
        w_issue  = issue_valid && !reset && (issue_index != 5'd0);
`else
        w_commit = w_handshake;
        w_issue  = issue_valid && !reset;
`endif
        w_set_mask = w_issue  ? (32'd1 << issue_index) : 32'd0;
        w_clr_mask = w_commit ? (32'd1 << w_sel_index) : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant   <= 1'b1;
            r_write_enable <= 1'b0;
            r_write_index  <= 5'd0;
            r_write_data   <= 16'd0;
            r_busy         <= 32'd0;
        end else begin
            r_write_enable <= w_commit;
            if (w_handshake) begin
                r_write_index <= w_sel_index;
                r_write_data  <= w_sel_data;
                r_last_grant  <= w_grant_mem;
            end
            // set mask applied after clear so a same-edge reservation wins
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign alu_ready    = w_grant_alu;
    assign mem_ready    = w_grant_mem;
    assign write_enable = r_write_enable;
    assign write_index  = r_write_index;
    assign write_data   = r_write_data;
    assign busy         = r_busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a behavioural arbitration model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_index = 5'd0;
    logic [15:0] alu_data = 16'd0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_index = 5'd0;
    logic [15:0] mem_data = 16'd0;
    logic        mem_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_index = 5'd0;
    logic        write_enable;
    logic [4:0]  write_index;
    logic [15:0] write_data;
    logic [31:0] busy;

    wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_index(mem_index), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_index(issue_index),
        .write_enable(write_enable), .write_index(write_index), .write_data(write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    bit          exp_last;
    bit          exp_we;
    logic [4:0]  exp_idx;
    logic [15:0] exp_data;
    logic [31:0] exp_busy;
    logic [15:0] ref_rf [32];
    logic [15:0] tb_rf [32];
    bit          p_ga;
    bit          p_gm;

    function automatic bit idx_ok(input logic [4:0] i);
`ifdef R0_ZERO_EN
        return i != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        exp_last = 1'b1;
        exp_we   = 1'b0;
        exp_idx  = 5'd0;
        exp_data = 16'd0;
        exp_busy = 32'd0;
    endtask

    task automatic predict();
        p_ga = 1'b0;
        p_gm = 1'b0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                if (exp_last) p_ga = 1'b1;
                else          p_gm = 1'b1;
            end else begin
                p_ga = alu_valid;
                p_gm = mem_valid;
            end
        end
    endtask

    task automatic tick();
        logic [4:0]  i;
        logic [15:0] d;
        predict();
        @(posedge clk);
        if (p_ga || p_gm) begin
            i = p_gm ? mem_index : alu_index;
            d = p_gm ? mem_data  : alu_data;
            exp_idx  = i;
            exp_data = d;
            exp_last = p_gm;
            exp_we   = idx_ok(i);
            if (exp_we) begin
                exp_busy[i] = 1'b0;
                ref_rf[i]   = d;
            end
        end else begin
            exp_we = 1'b0;
        end
        if (issue_valid && idx_ok(issue_index)) exp_busy[issue_index] = 1'b1;
        #1;
        if (write_enable === 1'b1) tb_rf[write_index] = write_data;
    endtask

    task automatic test_reset();
        alu_valid = 1'b1; alu_index = 5'd4; alu_data = 16'hBEEF;
        mem_valid = 1'b1; mem_index = 5'd6; mem_data = 16'h1111;
        issue_valid = 1'b1; issue_index = 5'd3;
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if ({write_enable, write_index, write_data, busy} !== 54'd0) begin
            n_err++;
            $display("FAIL reset_outputs got we=%b idx=%0d data=%h busy=%h exp all 0", write_enable, write_index, write_data, busy);
        end
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready got %b%b exp 00", alu_ready, mem_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 32'd0) begin
            n_err++;
            $display("FAIL reset_issue_ignored got busy=%h exp 0", busy);
        end
        reset = 1'b0;
        issue_valid = 1'b0;
        model_reset();
        predict();
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL first_contention got %b%b exp 10", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        n_chk++;
        if ({write_enable, write_index, write_data} !== {1'b1, 5'd4, 16'hBEEF}) begin
            n_err++;
            $display("FAIL first_write got we=%b idx=%0d data=%h exp 1/4/beef", write_enable, write_index, write_data);
        end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_index = 5'd10; alu_data = 16'h0077;
        issue_valid = 1'b1; issue_index = 5'd12;
        tick();
        alu_valid = 1'b0; issue_valid = 1'b0;
        n_chk++;
        if ({write_enable, busy} !== {exp_we, exp_busy}) begin
            n_err++;
            $display("FAIL pre_reset_write got we=%b busy=%h exp %b %h", write_enable, busy, exp_we, exp_busy);
        end
        #2 reset = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        n_chk++;
        if ({write_enable, write_index, write_data, busy, alu_ready, mem_ready} !== 56'd0) begin
            n_err++;
            $display("FAIL mid_reset got we=%b idx=%0d data=%h busy=%h rdy=%b%b exp all 0", write_enable, write_index, write_data, busy, alu_ready, mem_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        n_chk++;
        if ({write_enable, write_index, write_data, busy} !== 54'd0) begin
            n_err++;
            $display("FAIL post_reset_no_pulse got we=%b idx=%0d data=%h busy=%h exp all 0", write_enable, write_index, write_data, busy);
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_index = 5'd5; alu_data = 16'h1234;
        predict();
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL single_ready got %b%b exp 10", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_chk++;
        if ({write_enable, write_index, write_data} !== {1'b1, 5'd5, 16'h1234}) begin
            n_err++;
            $display("FAIL single_write got we=%b idx=%0d data=%h exp 1/5/1234", write_enable, write_index, write_data);
        end
        tick();
        n_chk++;
        if ({write_enable, write_index, write_data} !== {1'b0, 5'd5, 16'h1234}) begin
            n_err++;
            $display("FAIL single_idle_hold got we=%b idx=%0d data=%h exp 0/5/1234", write_enable, write_index, write_data);
        end
    endtask

    task automatic test_alternate();
        bit prev_ga;
        alu_valid = 1'b1; alu_index = 5'd1; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_index = 5'd2; mem_data = 16'h5555;
        prev_ga = 1'b0;
        for (int k = 0; k < 4; k++) begin
            predict();
            #1;
            n_chk++;
            if ({alu_ready, mem_ready} !== {p_ga, p_gm}) begin
                n_err++;
                $display("FAIL alt_ready[%0d] got %b%b exp %b%b", k, alu_ready, mem_ready, p_ga, p_gm);
            end
            if (k > 0) begin
                n_chk++;
                if (alu_ready === prev_ga) begin
                    n_err++;
                    $display("FAIL alt_toggle[%0d] got alu_ready=%b exp %b", k, alu_ready, !prev_ga);
                end
            end
            prev_ga = alu_ready;
            tick();
            n_chk++;
            if ({write_enable, write_index, write_data} !== {exp_we, exp_idx, exp_data}) begin
                n_err++;
                $display("FAIL alt_write[%0d] got %b/%0d/%h exp %b/%0d/%h", k, write_enable, write_index, write_data, exp_we, exp_idx, exp_data);
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_index = 5'd7;
        tick();
        issue_valid = 1'b0;
        n_chk++;
        if (busy[7] !== 1'b1) begin
            n_err++;
            $display("FAIL busy_set got %b exp 1", busy[7]);
        end
        tick();
        tick();
        alu_valid = 1'b1; alu_index = 5'd7; alu_data = 16'hC0DE;
        tick();
        alu_valid = 1'b0;
        n_chk++;
        if ({write_enable, busy[7], busy} !== {1'b1, 1'b0, exp_busy}) begin
            n_err++;
            $display("FAIL busy_clear got we=%b busy=%h exp 1 %h", write_enable, busy, exp_busy);
        end
        issue_valid = 1'b1;
        tick();
        alu_valid = 1'b1; alu_data = 16'hC0DF;
        tick();
        alu_valid = 1'b0; issue_valid = 1'b0;
        n_chk++;
        if ({write_enable, busy[7]} !== 2'b11) begin
            n_err++;
            $display("FAIL busy_set_wins got we=%b busy7=%b exp 1 1", write_enable, busy[7]);
        end
        alu_valid = 1'b1; alu_data = 16'hC0E0;
        tick();
        alu_valid = 1'b0;
        tick();
    endtask

    task automatic test_r0();
        issue_valid = 1'b1; issue_index = 5'd0;
        tick();
        issue_valid = 1'b0;
        n_chk++;
`ifdef R0_ZERO_EN
        if (busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL r0_issue got busy0=%b exp 0", busy[0]);
        end
`else
        if (busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL r0_issue got busy0=%b exp 1", busy[0]);
        end
`endif
        alu_valid = 1'b1; alu_index = 5'd0; alu_data = 16'hFFFF;
        predict();
        #1;
        n_chk++;
        if (alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL r0_ready got %b exp 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_chk++;
`ifdef R0_ZERO_EN
        if ({write_enable, busy[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL r0_write got we=%b busy0=%b exp 0 0", write_enable, busy[0]);
        end
`else
        if ({write_enable, write_index, write_data, busy[0]} !== {1'b1, 5'd0, 16'hFFFF, 1'b0}) begin
            n_err++;
            $display("FAIL r0_write got we=%b idx=%0d data=%h busy0=%b exp 1/0/ffff/0", write_enable, write_index, write_data, busy[0]);
        end
`endif
        tick();
    endtask

    task automatic test_same_index();
        logic [15:0] second;
        int          writes;
        alu_valid = 1'b1; alu_index = 5'd9; alu_data = 16'h0001;
        mem_valid = 1'b1; mem_index = 5'd9; mem_data = 16'h0002;
        second = 16'h0000;
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            if (alu_valid || mem_valid) begin
                predict();
                if (p_ga) second = 16'h0001;
                if (p_gm) second = 16'h0002;
                tick();
                if (p_ga) alu_valid = 1'b0;
                if (p_gm) mem_valid = 1'b0;
            end else begin
                tick();
            end
            if (write_enable === 1'b1 && write_index === 5'd9) writes++;
        end
        n_chk++;
        if (writes !== 2) begin
            n_err++;
            $display("FAIL same_idx_count got %0d exp 2", writes);
        end
        n_chk++;
        if (tb_rf[9] !== second || tb_rf[9] !== ref_rf[9]) begin
            n_err++;
            $display("FAIL same_idx_final got %h exp %h", tb_rf[9], second);
        end
    endtask

    task automatic test_random();
        bit ga;
        bit gm;
        for (int c = 0; c < 400; c++) begin
            predict();
            #1;
            n_chk++;
            if ({alu_ready, mem_ready} !== {p_ga, p_gm}) begin
                n_err++;
                $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", c, alu_ready, mem_ready, p_ga, p_gm);
            end
            ga = p_ga;
            gm = p_gm;
            tick();
            n_chk++;
            if ({write_enable, write_index, write_data, busy} !== {exp_we, exp_idx, exp_data, exp_busy}) begin
                n_err++;
                $display("FAIL rnd_out[%0d] got %b/%0d/%h/%h exp %b/%0d/%h/%h", c, write_enable, write_index, write_data, busy, exp_we, exp_idx, exp_data, exp_busy);
            end
            if (!alu_valid || ga) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_index = 5'($urandom);
                alu_data  = 16'($urandom);
            end
            if (!mem_valid || gm) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_index = 5'($urandom);
                mem_data  = 16'($urandom);
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_index = 5'($urandom);
        end
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 32; r++) begin
            n_chk++;
            if (tb_rf[r] !== ref_rf[r]) begin
                n_err++;
                $display("FAIL rnd_regfile[%0d] got %h exp %h", r, tb_rf[r], ref_rf[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            ref_rf[r] = 16'd0;
            tb_rf[r]  = 16'd0;
        end
        model_reset();
        test_reset();
        test_reset_mid();
        test_single_alu();
        test_alternate();
        test_scoreboard();
        test_r0();
        test_same_index();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  asynchronous, active-high reset.
REQ-003: alu_valid  input  1  ALU writeback request.
REQ-004: alu_index  input  5  ALU destination register.
REQ-005: alu_data  input  16  ALU result.
REQ-006: alu_ready  output  1  ALU request accepted this cycle, combinational.
REQ-007: mem_valid  input  1  load writeback request.
REQ-008: mem_index  input  5  load destination register.
REQ-009: mem_data  input  16  load data.
REQ-010: mem_ready  output  1  load request accepted this cycle, combinational.
REQ-011: issue_valid  input  1  issue stage reserves a destination register.
REQ-012: issue_index  input  5  register being reserved.
REQ-013: write_enable  output  1  registered; drives register-file write_enable.
REQ-014: write_index  output  5  registered; drives register-file write_index.
REQ-015: write_data  output  16  registered; drives register-file write_data.
REQ-016: busy  output  32  registered scoreboard; bit n set = write to register n pending.

Function
REQ-017: Shall share the register file's single write port between the ALU and load requesters; at most one handshake per cycle.
REQ-018: A handshake occurs when a requester's valid and ready are both 1; ready shall never be 1 while that requester's valid is 0.
REQ-019: Only one valid: that requester shall be granted (ready=1) in the same cycle.
REQ-020: Both valid: round-robin; grant the requester not granted last. 1-bit pointer last_grant (0=ALU, 1=MEM) updates only on a handshake.
REQ-021: Accepted request shall appear on write_enable/write_index/write_data on the next rising edge: exactly 1-cycle latency, write_enable high for exactly 1 cycle per handshake.
REQ-022: No handshake in a cycle: write_enable=0 next cycle; write_index/write_data hold their previous values.
REQ-023: busy[n] shall be set on the edge after issue_valid=1 with issue_index=n.
REQ-024: busy[n] shall be cleared on the edge on which write_enable is registered for index n, i.e., the same edge as REQ-021.
REQ-025: Set and clear to the same index on the same edge: set wins; busy[n] stays 1.
REQ-026: Two back-to-back writes to the same index shall commit in grant order; the later write determines the final register value.
REQ-027: A requester held valid while not granted shall keep index/data stable; the block shall not buffer ungranted requests.
REQ-028: Two contending requesters held continuously valid shall alternate grants every cycle; maximum wait 1 cycle.

Reset
REQ-029: When reset is asserted: write_enable=0, write_index=0, write_data=0, busy=0, last_grant=1 (ALU wins the first contention). Takes effect immediately, independent of clk.
REQ-030: While reset=1: alu_ready=0, mem_ready=0, and issue reservations are ignored.
REQ-031: Reset asserted mid-operation shall discard any in-flight registered write; no write_enable pulse follows the reset release.

Configuration
REQ-032: Macro R0_ZERO_EN.
- Defined: handshakes to index 0 complete normally, but write_enable stays 0 for them. Issue to index 0 does not set busy; busy[0] is constant 0. Round-robin pointer still advances.
- Undefined: index 0 is an ordinary register in all requirements.

Verification
REQ-033: Reset pulse mid-run -> all outputs 0, both readies 0 during reset; first contention after release grants ALU.
REQ-034: alu_valid=1 only, index 5, data 0x1234 at cycle t -> alu_ready=1 at t; write_enable=1, index 5, data 0x1234 at t+1; 0 at t+2.
REQ-035: Both valid for 4 cycles (ALU idx 1 data 0xAAAA, MEM idx 2 data 0x5555) -> grants ALU, MEM, ALU, MEM; four consecutive write pulses alternating.
REQ-036: issue idx 7 at t -> busy[7]=1 at t+1; ALU write idx 7 accepted at t+3 -> busy[7]=0 after the t+4 edge. Concurrent issue idx 7 at t+3 -> busy[7] stays 1.
REQ-037: With R0_ZERO_EN: ALU write idx 0 data 0xFFFF -> alu_ready=1, write_enable stays 0, busy[0]=0. Without the macro: write_enable=1, idx 0.
REQ-038: Both requesters target idx 9 (ALU 0x0001, MEM 0x0002) in contention -> two writes in grant order; final register value 0x0002 when MEM is granted second.
